// File: rtl/bomb_countdown_core.sv
// Bomb countdown controller: N-digit BCD down-counter with preset, pause,
// defuse/strike handling, strike-accelerated ticking and 7-segment drive.
//
// state      | meaning
// S_IDLE     | after reset, waiting for start
// S_RUN      | counting down
// S_PAUSED   | prescaler and digits held, strikes still counted
// S_DEFUSED  | digits frozen, start re-arms
// S_BOOM     | detonated, blinking "-" until reset
module bomb_countdown_core #(
  parameter int DIGITS       = 4,
  parameter int TICK_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int MAX_STRIKES  = 3
) (
  input  logic                         i_clk,
  input  logic                         i_async_nreset,
  input  logic                         i_start,
  input  logic [$clog2(DIGITS+1)-1:0]  i_preset_len,
  input  logic                         i_pause,
  input  logic                         i_defuse,
  input  logic                         i_strike,
  output logic [4*DIGITS-1:0]          o_bcd,
  output logic [8*DIGITS-1:0]          o_seg_n,
  output logic [1:0]                   o_state,
  output logic [2:0]                   o_strikes,
  output logic                         o_defused,
  output logic                         o_exploded
);

  localparam int PLW = $clog2(DIGITS + 1);
  localparam int PW  = $clog2(TICK_CYCLES + 1);
  localparam int BW  = $clog2(BLINK_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PAUSED  = 3'd2,
    S_DEFUSED = 3'd3,
    S_BOOM    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4*DIGITS-1:0] r_bcd;
  logic [PW-1:0]       r_presc;
  logic [2:0]          r_strikes;
  logic                r_blink;
  logic [BW-1:0]       r_btmr;

  logic                w_zero;
  logic                w_tick;
  logic                w_strike_max;
  logic [PW-1:0]       w_period_m1;

  function automatic logic [4*DIGITS-1:0] f_preset(input logic [PLW-1:0] len);
    int n;
    n = int'(len);
    if (n == 0) n = 1;
    if (n > DIGITS) n = DIGITS;
    f_preset = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < n) f_preset[4*i +: 4] = 4'd9;
    end
  endfunction

  // Borrow ripples up from digit 0; a zero digit wraps to 9 and keeps borrowing.
  function automatic logic [4*DIGITS-1:0] f_dec(input logic [4*DIGITS-1:0] d);
    logic borrow;
    f_dec  = d;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (d[4*i +: 4] == 4'd0) begin
          f_dec[4*i +: 4] = 4'd9;
        end else begin
          f_dec[4*i +: 4] = d[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 8'hC0;
      4'd1:    f_seg = 8'hF9;
      4'd2:    f_seg = 8'hA4;
      4'd3:    f_seg = 8'hB0;
      4'd4:    f_seg = 8'h99;
      4'd5:    f_seg = 8'h92;
      4'd6:    f_seg = 8'h82;
      4'd7:    f_seg = 8'hF8;
      4'd8:    f_seg = 8'h80;
      4'd9:    f_seg = 8'h90;
      default: f_seg = 8'hFF;
    endcase
  endfunction

  assign w_zero       = (r_bcd == '0);
  assign w_period_m1  = PW'((TICK_CYCLES >> r_strikes) - 1);
  assign w_tick       = (r_presc == w_period_m1);
  assign w_strike_max = ((r_strikes + 3'd1) == 3'(MAX_STRIKES));

  always_ff @(posedge i_clk or negedge i_async_nreset) begin
    if (!i_async_nreset) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DEFUSED: begin
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_zero)                        w_state_nxt = S_BOOM;
        else if (i_defuse)                 w_state_nxt = S_DEFUSED;
        else if (i_strike && w_strike_max) w_state_nxt = S_BOOM;
        else if (i_pause)                  w_state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (i_strike && w_strike_max) w_state_nxt = S_BOOM;
        else if (i_pause)             w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_BOOM;
    endcase
  end

  always_comb begin
    o_state    = 2'd0;
    o_defused  = 1'b0;
    o_exploded = 1'b0;
    case (r_state)
      S_RUN:     o_state = 2'd1;
      S_PAUSED:  o_state = 2'd2;
      S_DEFUSED: begin
        o_state   = 2'd2;
        o_defused = 1'b1;
      end
      S_BOOM: begin
        o_state    = 2'd3;
        o_exploded = 1'b1;
      end
      default: o_state = 2'd0;
    endcase
    o_seg_n = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_state == S_BOOM) o_seg_n[8*i +: 8] = r_blink ? 8'hBF : 8'hFF;
      else                   o_seg_n[8*i +: 8] = f_seg(r_bcd[4*i +: 4]);
    end
  end

  assign o_bcd     = r_bcd;
  assign o_strikes = r_strikes;

  always_ff @(posedge i_clk or negedge i_async_nreset) begin
    if (!i_async_nreset) begin
      r_bcd     <= '0;
      r_presc   <= '0;
      r_strikes <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DEFUSED: begin
          if (i_start) begin
            r_bcd     <= f_preset(i_preset_len);
            r_presc   <= '0;
            r_strikes <= '0;
          end
        end
        S_RUN: begin
          // Zero and defuse freeze everything; a strike restarts the tick period.
          if (!w_zero && !i_defuse) begin
            if (i_strike) begin
              r_strikes <= r_strikes + 3'd1;
              r_presc   <= '0;
            end else if (!i_pause) begin
              if (w_tick) begin
                r_bcd   <= f_dec(r_bcd);
                r_presc <= '0;
              end else begin
                r_presc <= r_presc + PW'(1);
              end
            end
          end
        end
        S_PAUSED: begin
          if (i_strike) begin
            r_strikes <= r_strikes + 3'd1;
            r_presc   <= '0;
          end
        end
        default: begin
          r_bcd <= r_bcd;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_async_nreset) begin
    if (!i_async_nreset) begin
      r_blink <= 1'b0;
      r_btmr  <= '0;
    end else if (r_state != S_BOOM) begin
      if (w_state_nxt == S_BOOM) begin
        r_blink <= 1'b1;
        r_btmr  <= '0;
      end
    end else if (r_btmr == BW'(BLINK_CYCLES - 1)) begin
      r_btmr  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_btmr <= r_btmr + BW'(1);
    end
  end

endmodule

// File: tb/tb_bomb_countdown_core.sv
// Directed bench for bomb_countdown_core with DIGITS=2, TICK_CYCLES=8,
// BLINK_CYCLES=4, MAX_STRIKES=2; expected values are hand-derived.
module tb_bomb_countdown_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  preset_len;
  logic        pause;
  logic        defuse;
  logic        strike;
  logic [7:0]  bcd;
  logic [15:0] seg_n;
  logic [1:0]  state;
  logic [2:0]  strikes;
  logic        defused;
  logic        exploded;

  int n_tests = 0;
  int n_fail  = 0;

  bomb_countdown_core #(
    .DIGITS(2), .TICK_CYCLES(8), .BLINK_CYCLES(4), .MAX_STRIKES(2)
  ) dut (
    .i_clk(clk),
    .i_async_nreset(rst_n),
    .i_start(start),
    .i_preset_len(preset_len),
    .i_pause(pause),
    .i_defuse(defuse),
    .i_strike(strike),
    .o_bcd(bcd),
    .o_seg_n(seg_n),
    .o_state(state),
    .o_strikes(strikes),
    .o_defused(defused),
    .o_exploded(exploded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_bcd",      32'(bcd),      32'h00);
    check("rst_state",    32'(state),    32'd0);
    check("rst_seg",      32'(seg_n),    32'hC0C0);
    check("rst_strikes",  32'(strikes),  32'd0);
    check("rst_exploded", 32'(exploded), 32'd0);
    check("rst_defused",  32'(defused),  32'd0);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; preset_len = 2'd0;
    pause = 1'b0; defuse = 1'b0; strike = 1'b0;
    #12 rst_n = 1'b1;

    tick(20);
    check("idle_bcd",   32'(bcd),   32'h00);
    check("idle_state", 32'(state), 32'd0);
    check("idle_seg",   32'(seg_n), 32'hC0C0);

    // preset 1 digit, count to zero, detonate, blink
    preset_len = 2'd1; start = 1'b1; tick(1); start = 1'b0;
    check("p1_bcd",   32'(bcd),   32'h09);
    check("p1_state", 32'(state), 32'd1);
    check("p1_seg",   32'(seg_n), 32'hC090);
    tick(7);
    check("p1_pre_tick", 32'(bcd), 32'h09);
    tick(1);
    check("p1_tick1",     32'(bcd),   32'h08);
    check("p1_tick1_seg", 32'(seg_n), 32'hC080);
    tick(64);
    check("p1_zero_bcd",   32'(bcd),      32'h00);
    check("p1_zero_state", 32'(state),    32'd1);
    check("p1_zero_expl",  32'(exploded), 32'd0);
    tick(1);
    check("boom_expl",  32'(exploded), 32'd1);
    check("boom_state", 32'(state),    32'd3);
    check("boom_on0",   32'(seg_n),    32'hBFBF);
    tick(3);
    check("boom_on3",   32'(seg_n),    32'hBFBF);
    tick(1);
    check("boom_off",   32'(seg_n),    32'hFFFF);
    tick(4);
    check("boom_on2",   32'(seg_n),    32'hBFBF);
    check("boom_bcd",   32'(bcd),      32'h00);
    pulse_reset();

    // clamped preset, borrow, strikes, strike beats tick
    preset_len = 2'd3; start = 1'b1; tick(1); start = 1'b0;
    check("p3_bcd", 32'(bcd), 32'h99);
    tick(72);
    check("p3_nine_ticks", 32'(bcd), 32'h90);
    tick(8);
    check("p3_borrow", 32'(bcd), 32'h89);
    strike = 1'b1; tick(1); strike = 1'b0;
    check("s1_strikes", 32'(strikes), 32'd1);
    check("s1_state",   32'(state),   32'd1);
    tick(3);
    check("s1_pre_tick", 32'(bcd), 32'h89);
    tick(1);
    check("s1_fast_tick", 32'(bcd), 32'h88);
    tick(3);
    check("s1_pre_tick2", 32'(bcd), 32'h88);
    strike = 1'b1; tick(1); strike = 1'b0;
    check("s2_state",   32'(state),    32'd3);
    check("s2_expl",    32'(exploded), 32'd1);
    check("s2_strikes", 32'(strikes),  32'd2);
    check("s2_no_dec",  32'(bcd),      32'h88);
    pulse_reset();

    // pause/resume, defuse beats tick, re-arm with preset 0
    preset_len = 2'd2; start = 1'b1; tick(1); start = 1'b0;
    check("p2_bcd", 32'(bcd), 32'h99);
    tick(32);
    check("p2_95", 32'(bcd), 32'h95);
    pause = 1'b1; tick(1); pause = 1'b0;
    check("pause_state",   32'(state),   32'd2);
    check("pause_defused", 32'(defused), 32'd0);
    tick(30);
    check("pause_hold_bcd",   32'(bcd),   32'h95);
    check("pause_hold_state", 32'(state), 32'd2);
    pause = 1'b1; tick(1); pause = 1'b0;
    check("resume_state", 32'(state), 32'd1);
    tick(7);
    check("resume_pre_tick", 32'(bcd), 32'h95);
    tick(1);
    check("resume_tick", 32'(bcd), 32'h94);
    tick(7);
    defuse = 1'b1; tick(1); defuse = 1'b0;
    check("def_defused", 32'(defused),  32'd1);
    check("def_state",   32'(state),    32'd2);
    check("def_no_dec",  32'(bcd),      32'h94);
    check("def_expl",    32'(exploded), 32'd0);
    tick(10);
    check("def_frozen", 32'(bcd), 32'h94);
    preset_len = 2'd0; start = 1'b1; tick(1); start = 1'b0;
    check("rearm_bcd",     32'(bcd),     32'h09);
    check("rearm_state",   32'(state),   32'd1);
    check("rearm_defused", 32'(defused), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_countdown_core.md
# bomb_countdown_core

Parametrised bomb countdown controller: N-digit BCD down-counter with selectable preset, pause/resume, defuse and strike inputs, and strike-accelerated ticking. Drives N active-low 7-segment displays with a blinking "-" pattern on detonation. It is the successor to the fixed 4-digit controller and sits between the password/keypad block (defuse/strike pulses) and the board displays.

## Interface
- DIGITS, 4, number of BCD digits / displays (1..8)
- TICK_CYCLES, 50_000_000, clk cycles per countdown tick at zero strikes; must be ≥ 2^MAX_STRIKES
- BLINK_CYCLES, 25_000_000, clk cycles per blink half-period in BOOM
- MAX_STRIKES, 3, strike count that triggers detonation (1..7)

- clk  in  1  system clock, rising edge
- async_nreset  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: arm and begin countdown
- preset_len  in  clog2(DIGITS+1)  number of low digits loaded with 9; 0 treated as 1, >DIGITS clamped to DIGITS
- pause  in  1  single-cycle pulse: toggle RUN/PAUSED
- defuse  in  1  single-cycle pulse: correct code entered
- strike  in  1  single-cycle pulse: wrong code entered
- bcd  out  4*DIGITS  current digits, digit 0 in [3:0]
- seg_n  out  8*DIGITS  active-low segments {dp,g..a} per digit, digit 0 in [7:0]
- state  out  2  0 IDLE, 1 RUN, 2 PAUSED/DEFUSED (see defused), 3 BOOM
- strikes  out  3  strike count
- defused  out  1  high in DEFUSED
- exploded  out  1  high in BOOM

## Operation
- States: IDLE, RUN, PAUSED, DEFUSED, BOOM (state output encodes PAUSED and DEFUSED as 2, distinguished by defused).
- Reset: IDLE, all digits 0, strikes 0, prescaler 0, blink OFF; outputs bcd=0, seg_n shows "0" on every digit (8'hC0), defused=0, exploded=0.
- IDLE/DEFUSED: start → RUN; low min(max(preset_len,1),DIGITS) digits load 9, others 0; prescaler and strikes cleared. Other inputs ignored.
- RUN, priority per cycle: (1) registered digits all zero → BOOM; (2) defuse → DEFUSED, digits frozen; (3) strike making strikes==MAX_STRIKES → BOOM; (4) pause → PAUSED; (5) tick → decrement.
- Strike below limit: strikes+1, prescaler cleared; tick period becomes TICK_CYCLES >> strikes.
- Decrement: BCD borrow chain; digit 0 at 0 wraps to 9 and borrows from next; digits never exceed 9.
- PAUSED: prescaler held; pause → RUN; strike still counted (may reach BOOM); defuse/start ignored.
- BOOM: terminal until reset. Blink toggles every BLINK_CYCLES; entry sets blink ON, blink timer cleared. ON: all seg_n = 8'hBF ("-"); OFF: 8'hFF.
- seg_n outside BOOM: decode of bcd, dp off; codes 0–9 standard active-low (0=C0,1=F9,…,9=90).

## Timing
- All outputs registered state or combinational decode of registered state; no input-to-output paths.
- start in IDLE at cycle t: state=RUN and preset on bcd at t+1.
- Tick: prescaler counts 0..period-1 in RUN; on terminal count bcd updates next cycle; first tick after start at t+1+period.
- Zero detection uses registered digits: bcd reaches 0 at cycle u → exploded=1 at u+1.
- defuse and tick same cycle: defuse wins, no decrement. strike and tick same cycle: strike wins, prescaler restart.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

## Test plan
Params DIGITS=2, TICK_CYCLES=8, BLINK_CYCLES=4, MAX_STRIKES=2.
- Reset then idle 20 cycles → bcd=0x00, state=0, seg_n=16'hC0C0.
- start, preset_len=1 → bcd=0x09 next cycle; decrements every 8 cycles; 0x00 reached, exploded=1 one cycle later; seg_n alternates 16'hBFBF/16'hFFFF every 4 cycles.
- preset_len=3 (clamp) start → bcd=0x99; after 10 ticks bcd=0x89 (borrow across digits).
- strike once → strikes=1, tick period 4; second strike → BOOM next cycle.
- pause at bcd=0x95 for 30 cycles → bcd held; pause again → resumes, next tick 8 cycles later; defuse coincident with tick → defused=1, bcd frozen; start → reloads, RUN.
- Reset asserted during BOOM → all outputs reset values within the same cycle.
